// File: rtl/sample_decimator_if.sv
// Sample path bus for sample_decimator: upstream sample stream, runtime
// configuration and decimated output stream. The source side uses the master
// modport and the decimator uses the slave modport.
interface sample_decimator_if #(
  parameter int DATA_W   = 16,
  parameter int CH_N     = 2,
  parameter int FACTOR_W = 4
);
  logic [CH_N*DATA_W-1:0] datain;
  logic                   datain_valid;
  logic [FACTOR_W-1:0]    factor;
  logic                   mode;
  logic [2:0]             shift;
  logic                   frame_clr;
  logic [CH_N*DATA_W-1:0] dataout;
  logic                   dataout_valid;

  modport master (
    output datain, datain_valid, factor, mode, shift, frame_clr,
    input  dataout, dataout_valid
  );

  modport slave (
    input  datain, datain_valid, factor, mode, shift, frame_clr,
    output dataout, dataout_valid
  );
endinterface

// File: rtl/sample_decimator.sv
// sample_decimator: multi-channel decimator for the audio sample path.
// Every frame of N valid sample sets yields one output set, either the last
// sample of the frame (pick) or the shifted boxcar sum (average). All channels
// share one frame counter so channel alignment is preserved.
// Optional feature macro: DECIM_SAT_EN -- when defined, the shifted average is
// saturated to the signed DATA_W range; otherwise it is truncated (wraps).
module sample_decimator #(
  parameter int DATA_W   = 16,
  parameter int CH_N     = 2,
  parameter int FACTOR_W = 4
) (
  input logic               clk,
  input logic               rst_n,
  sample_decimator_if.slave bus
);
  localparam int ACC_W = DATA_W + FACTOR_W;

`ifdef DECIM_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(1 << (DATA_W - 1)));
`endif

  logic [FACTOR_W-1:0]    cnt_q;
  logic [FACTOR_W-1:0]    nLat_q;
  logic                   modeLat_q;
  logic [2:0]             shiftLat_q;
  logic [CH_N*ACC_W-1:0]  acc_q;
  logic [CH_N*ACC_W-1:0]  acc_d;
  logic [CH_N*DATA_W-1:0] dataout_q;
  logic [CH_N*DATA_W-1:0] dataout_d;
  logic                   dataoutValid_q;

  logic                   startFrame;
  logic [FACTOR_W-1:0]    factorEff;
  logic [FACTOR_W-1:0]    nUse;
  logic                   modeUse;
  logic [2:0]             shiftUse;
  logic [FACTOR_W-1:0]    curCnt;
  logic                   lastCnt;
  logic                   complete;

  // A sample opens a frame when the counter is idle or frame_clr restarts it;
  // on that cycle the live factor/mode/shift apply instead of the latched ones.
  assign startFrame = bus.datain_valid && (bus.frame_clr || (cnt_q == '0));
  assign factorEff  = (bus.factor == '0) ? FACTOR_W'(1) : bus.factor;
  assign nUse       = startFrame ? factorEff : nLat_q;
  assign modeUse    = startFrame ? bus.mode : modeLat_q;
  assign shiftUse   = startFrame ? bus.shift : shiftLat_q;
  assign curCnt     = bus.frame_clr ? '0 : cnt_q;
  assign lastCnt    = (curCnt == (nUse - FACTOR_W'(1)));
  assign complete   = bus.datain_valid && lastCnt;

  // Per-channel datapath: accumulate, then either pick the live sample or
  // reduce the shifted sum to DATA_W bits when the frame completes.
  for (genvar ch = 0; ch < CH_N; ch++) begin : gChan
    logic signed [DATA_W-1:0] sample;
    logic signed [ACC_W-1:0]  sampleExt;
    logic signed [ACC_W-1:0]  base;
    logic signed [ACC_W-1:0]  sum;
    logic [DATA_W-1:0]        avgRes;

    assign sample    = bus.datain[ch*DATA_W +: DATA_W];
    assign sampleExt = {{FACTOR_W{sample[DATA_W-1]}}, sample};
    assign base      = (curCnt == '0) ? '0 : acc_q[ch*ACC_W +: ACC_W];
    assign sum       = base + sampleExt;

`ifdef DECIM_SAT_EN
    logic signed [ACC_W-1:0] shifted;
    assign shifted = sum >>> shiftUse;
    assign avgRes  = (shifted > SAT_MAX) ? SAT_MAX[DATA_W-1:0] :
                     (shifted < SAT_MIN) ? SAT_MIN[DATA_W-1:0] :
                     shifted[DATA_W-1:0];
`else
    assign avgRes  = DATA_W'(sum >>> shiftUse);
`endif

    assign acc_d[ch*ACC_W +: ACC_W]       = lastCnt ? '0 : sum;
    assign dataout_d[ch*DATA_W +: DATA_W] = modeUse ? avgRes : sample;
  end

  // Frame counter, latched frame configuration, accumulators and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      nLat_q         <= FACTOR_W'(1);
      modeLat_q      <= 1'b0;
      shiftLat_q     <= '0;
      acc_q          <= '0;
      dataout_q      <= '0;
      dataoutValid_q <= 1'b0;
    end else begin
      dataoutValid_q <= complete;
      if (bus.datain_valid) begin
        cnt_q <= lastCnt ? '0 : (curCnt + FACTOR_W'(1));
        acc_q <= acc_d;
        if (startFrame) begin
          nLat_q     <= factorEff;
          modeLat_q  <= bus.mode;
          shiftLat_q <= bus.shift;
        end
        if (lastCnt) begin
          dataout_q <= dataout_d;
        end
      end else if (bus.frame_clr) begin
        cnt_q <= '0;
        acc_q <= '0;
      end
    end
  end

  assign bus.dataout       = dataout_q;
  assign bus.dataout_valid = dataoutValid_q;
endmodule

// File: tb/tb_sample_decimator.sv
// tb_sample_decimator: directed bench for sample_decimator with a frame-queue
// reference model and literal checkpoints. Honours DECIM_SAT_EN when defined.
module tb_sample_decimator;
  localparam int DATA_W   = 16;
  localparam int CH_N     = 2;
  localparam int FACTOR_W = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int  total = 0;
  int  bad   = 0;
  bit  compareOn = 1'b0;

  // reference model state: samples of the open frame and the expected outputs
  int  frameQ[CH_N][$];
  int  mN;
  int  mMode;
  int  mShift;
  int  expValid;
  int  expData[CH_N];

  always #5 clk = ~clk;

  sample_decimator_if #(.DATA_W(DATA_W), .CH_N(CH_N), .FACTOR_W(FACTOR_W)) bus ();

  sample_decimator #(.DATA_W(DATA_W), .CH_N(CH_N), .FACTOR_W(FACTOR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic compareVal(input string name, input logic signed [31:0] act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int wrapData(input int v);
    logic signed [DATA_W-1:0] t;
    t = v[DATA_W-1:0];
    return int'(t);
  endfunction

  function automatic int reduceAvg(input int v);
`ifdef DECIM_SAT_EN
    if (v > (2 ** (DATA_W - 1)) - 1) return (2 ** (DATA_W - 1)) - 1;
    if (v < -(2 ** (DATA_W - 1))) return -(2 ** (DATA_W - 1));
    return v;
`else
    return wrapData(v);
`endif
  endfunction

  function automatic int chanOf(input int ch);
    logic signed [DATA_W-1:0] t;
    t = bus.dataout[ch*DATA_W +: DATA_W];
    return int'(t);
  endfunction

  task automatic modelReset();
    for (int ch = 0; ch < CH_N; ch++) begin
      frameQ[ch].delete();
      expData[ch] = 0;
    end
    mN = 1; mMode = 0; mShift = 0; expValid = 0;
  endtask

  // frame-level model: collect samples; when N are held, emit last or shifted sum
  task automatic modelStep(input bit valid, input bit clr, input int factor,
                           input bit mode, input int shift, input int d0, input int d1);
    int s;
    expValid = 0;
    if (clr) for (int ch = 0; ch < CH_N; ch++) frameQ[ch].delete();
    if (valid) begin
      if (frameQ[0].size() == 0) begin
        mN = (factor == 0) ? 1 : factor;
        mMode = mode;
        mShift = shift;
      end
      frameQ[0].push_back(wrapData(d0));
      frameQ[1].push_back(wrapData(d1));
      if (frameQ[0].size() == mN) begin
        expValid = 1;
        for (int ch = 0; ch < CH_N; ch++) begin
          if (mMode == 0) begin
            expData[ch] = frameQ[ch][$];
          end else begin
            s = 0;
            foreach (frameQ[ch][k]) s += frameQ[ch][k];
            expData[ch] = reduceAvg(s >>> mShift);
          end
          frameQ[ch].delete();
        end
      end
    end
  endtask

  task automatic applyStimulus(input bit valid, input int d0, input int d1, input int factor,
                               input bit mode, input int shift, input bit clr);
    bus.datain       = {DATA_W'(d1), DATA_W'(d0)};
    bus.datain_valid = valid;
    bus.factor       = FACTOR_W'(factor);
    bus.mode         = mode;
    bus.shift        = 3'(shift);
    bus.frame_clr    = clr;
    @(posedge clk);
    #1;
    modelStep(valid, clr, factor, mode, shift, d0, d1);
  endtask

  task automatic checkOutput(input string name, input int ev, input int e0, input int e1);
    compareVal({name, "_valid"}, {31'd0, bus.dataout_valid}, ev);
    compareVal({name, "_ch0"}, chanOf(0), e0);
    compareVal({name, "_ch1"}, chanOf(1), e1);
  endtask

  // every cycle the DUT outputs must match the model
  always @(negedge clk) begin
    if (compareOn) begin
      compareVal("model_valid", {31'd0, bus.dataout_valid}, expValid);
      for (int ch = 0; ch < CH_N; ch++)
        compareVal($sformatf("model_ch%0d", ch), chanOf(ch), expData[ch]);
    end
  end

  initial begin
    bus.datain = '0; bus.datain_valid = 1'b0; bus.factor = '0;
    bus.mode = 1'b0; bus.shift = '0; bus.frame_clr = 1'b0;
    modelReset();
    #1 rst_n = 1'b0;
    #1 compareOn = 1'b1;
    checkOutput("reset", 0, 0, 0);
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1'b1;

    // pick, factor 4
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1, i, 10 * i, 4, 0, 0, 0);
      if (i == 4) checkOutput("pick_a", 1, 4, 40);
      if (i == 5) checkOutput("pick_hold", 0, 4, 40);
      if (i == 8) checkOutput("pick_b", 1, 8, 80);
    end
    applyStimulus(0, 0, 0, 4, 0, 0, 0);

    // average, factor 4, shift 2, with an idle cycle mid-frame
    applyStimulus(1, 100, -4, 4, 1, 2, 0);
    applyStimulus(1, 200, -4, 4, 1, 2, 0);
    applyStimulus(0, 0, 0, 4, 1, 2, 0);
    applyStimulus(1, 300, -4, 4, 1, 2, 0);
    applyStimulus(1, 400, -4, 4, 1, 2, 0);
    checkOutput("avg", 1, 250, -4);

    // overflowing average, shift 0
    for (int i = 0; i < 4; i++) applyStimulus(1, 32767, -32768, 4, 1, 0, 0);
`ifdef DECIM_SAT_EN
    checkOutput("sat", 1, 32767, -32768);
`else
    checkOutput("wrap", 1, -4, 0);
`endif

    // factor changed mid-frame: 3 latched, 2 from the next frame
    applyStimulus(1, 11, -11, 3, 0, 0, 0);
    applyStimulus(1, 12, -12, 2, 0, 0, 0);
    applyStimulus(1, 13, -13, 2, 0, 0, 0);
    checkOutput("mid_13", 1, 13, -13);
    applyStimulus(1, 14, -14, 2, 0, 0, 0);
    applyStimulus(1, 15, -15, 2, 0, 0, 0);
    checkOutput("mid_15", 1, 15, -15);
    applyStimulus(1, 16, -16, 2, 0, 0, 0);
    applyStimulus(1, 17, -17, 2, 0, 0, 0);
    checkOutput("mid_17", 1, 17, -17);

    // frame_clr with valid on the third sample of a factor-4 frame
    applyStimulus(1, 21, -21, 4, 0, 0, 0);
    applyStimulus(1, 22, -22, 4, 0, 0, 0);
    applyStimulus(1, 23, -23, 4, 0, 0, 1);
    applyStimulus(1, 24, -24, 4, 0, 0, 0);
    applyStimulus(1, 25, -25, 4, 0, 0, 0);
    checkOutput("clr_hold", 0, 17, -17);
    applyStimulus(1, 26, -26, 4, 0, 0, 0);
    checkOutput("clr_out", 1, 26, -26);

    // factor 0 and 1 behave as pass-through
    applyStimulus(1, 31, -31, 0, 0, 0, 0);
    checkOutput("f0_a", 1, 31, -31);
    applyStimulus(1, 32, -32, 0, 1, 0, 0);
    checkOutput("f0_b", 1, 32, -32);
    applyStimulus(1, 33, -33, 1, 0, 0, 0);
    checkOutput("f1_a", 1, 33, -33);
    applyStimulus(1, 34, -34, 1, 0, 0, 0);
    checkOutput("f1_b", 1, 34, -34);

    // asynchronous reset in the middle of a frame
    applyStimulus(1, 41, -41, 4, 0, 0, 0);
    applyStimulus(1, 42, -42, 4, 0, 0, 0);
    bus.datain_valid = 1'b0;
    rst_n = 1'b0;
    modelReset();
    #2;
    checkOutput("rst_mid", 0, 0, 0);
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1'b1;
    applyStimulus(1, 43, -43, 4, 0, 0, 0);
    applyStimulus(1, 44, -44, 4, 0, 0, 0);
    applyStimulus(1, 45, -45, 4, 0, 0, 0);
    checkOutput("rst_fresh", 0, 0, 0);
    applyStimulus(1, 46, -46, 4, 0, 0, 0);
    checkOutput("rst_out", 1, 46, -46);
    applyStimulus(0, 0, 0, 4, 0, 0, 0);
    applyStimulus(0, 0, 0, 4, 0, 0, 0);

    compareOn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
